// File: rtl/psd_regfile_pkg.sv
// Shared constants for the psd_chip configuration register file:
// default geometry, named register indices and the instance reset/RO maps.
package psd_regfile_pkg;

  localparam int unsigned PSD_WIDTH   = 8;
  localparam int unsigned PSD_ADDRW   = 8;
  localparam int unsigned PSD_NUMREGS = 16;
  localparam int unsigned PSD_ERRW    = 4;

  localparam int unsigned REG_GAIN    = 0;
  localparam int unsigned REG_OFFSET  = 1;
  localparam int unsigned REG_TRIM    = 2;
  localparam int unsigned REG_BIAS    = 3;
  localparam int unsigned REG_CHIP_ID = 7;

  localparam logic [PSD_WIDTH-1:0] BIAS_RESET = 8'hA5;

  function automatic logic [PSD_NUMREGS*PSD_WIDTH-1:0] psd_defaults();
    logic [PSD_NUMREGS*PSD_WIDTH-1:0] d;
    d = '0;
    d[REG_BIAS*PSD_WIDTH +: PSD_WIDTH] = BIAS_RESET;
    return d;
  endfunction

  function automatic logic [PSD_NUMREGS-1:0] psd_ro_mask();
    logic [PSD_NUMREGS-1:0] m;
    m = '0;
    m[REG_CHIP_ID] = 1'b1;
    return m;
  endfunction

  localparam logic [PSD_NUMREGS*PSD_WIDTH-1:0] PSD_DEFAULTS = psd_defaults();
  localparam logic [PSD_NUMREGS-1:0]           PSD_RO_MASK  = psd_ro_mask();

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clear wins.
module sat_counter #(
  parameter int unsigned W = 4
)(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 count <= '0;
    else if (clear)               count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/config_regfile.sv
// Configuration register file: per-register defaults, RO masking, registered
// readback, optional shadow/commit bank and saturating address-error counter.
module config_regfile
  import psd_regfile_pkg::*;
#(
  parameter int unsigned               WIDTH     = PSD_WIDTH,
  parameter int unsigned               NUMREGS   = PSD_NUMREGS,
  parameter int unsigned               ADDRW     = PSD_ADDRW,
  parameter bit                        SHADOW_EN = 1'b0,
  parameter logic [NUMREGS*WIDTH-1:0]  DEFAULTS  = '0,
  parameter logic [NUMREGS-1:0]        RO_MASK   = '0,
  parameter int unsigned               ERRW      = PSD_ERRW
)(
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] config_bits [0:NUMREGS-1],
  input  logic             write,
  input  logic [ADDRW-1:0] write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read,
  input  logic [ADDRW-1:0] read_addr,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  input  logic             commit,
  input  logic             soft_reset,
  output logic             dirty,
  output logic             addr_err,
  output logic [ERRW-1:0]  err_count
);

  localparam int unsigned IDXW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;

  logic [WIDTH-1:0] shadow [0:NUMREGS-1];
  logic [IDXW-1:0]  wa_idx, ra_idx;
  logic             w_in, r_in, wr_ok, wr_err, rd_err, err_evt;

  assign wa_idx = write_addr[IDXW-1:0];
  assign ra_idx = read_addr[IDXW-1:0];
  assign w_in   = 32'(write_addr) < NUMREGS;
  assign r_in   = 32'(read_addr)  < NUMREGS;

  // Range is checked first so the RO lookup never uses an aliased index.
  assign wr_ok   = write && w_in && !RO_MASK[wa_idx];
  assign wr_err  = write && !wr_ok;
  assign rd_err  = read && !r_in;
  assign err_evt = wr_err || rd_err;

  for (genvar i = 0; i < NUMREGS; i++) begin : g_reg
    localparam logic [WIDTH-1:0] DFLT = DEFAULTS[i*WIDTH +: WIDTH];
    logic hit;
    assign hit = wr_ok && (wa_idx == IDXW'(i));

    // Commit copies the pre-edge shadow, so a same-cycle write stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 config_bits[i] <= DFLT;
      else if (soft_reset)          config_bits[i] <= DFLT;
      else if (SHADOW_EN && commit) config_bits[i] <= shadow[i];
      else if (!SHADOW_EN && hit)   config_bits[i] <= write_data;
    end

    if (SHADOW_EN) begin : g_sh
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        shadow[i] <= DFLT;
        else if (soft_reset) shadow[i] <= DFLT;
        else if (hit)        shadow[i] <= write_data;
      end
    end else begin : g_dir
      assign shadow[i] = config_bits[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        dirty <= 1'b0;
    else if (soft_reset) dirty <= 1'b0;
    else                 dirty <= SHADOW_EN && (wr_ok || (dirty && !commit));
  end

  // Readback samples pre-edge bank contents: read-before-write on collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= read;
      addr_err   <= err_evt;
      if (read) read_data <= r_in ? shadow[ra_idx] : '0;
    end
  end

  sat_counter #(.W(ERRW)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_evt),
    .clear   (soft_reset),
    .count   (err_count)
  );

endmodule

// File: tb/tb_config_regfile.sv
// Directed bench: one direct-write and one shadow/commit instance share stimulus.
module tb_config_regfile;
  import psd_regfile_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write, read, commit, soft_reset;
  logic [7:0] write_addr, read_addr, write_data;

  logic [7:0] cb_d [0:15];
  logic [7:0] cb_s [0:15];
  logic [7:0] rd_d, rd_s;
  logic       rv_d, rv_s, dirty_d, dirty_s, ae_d, ae_s;
  logic [3:0] ec_d, ec_s;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  config_regfile #(.WIDTH(8), .NUMREGS(16), .ADDRW(8), .SHADOW_EN(1'b0),
    .DEFAULTS(PSD_DEFAULTS), .RO_MASK(PSD_RO_MASK), .ERRW(4)) u_dir (
    .clk(clk), .reset_n(reset_n), .config_bits(cb_d), .write(write),
    .write_addr(write_addr), .write_data(write_data), .read(read),
    .read_addr(read_addr), .read_data(rd_d), .read_valid(rv_d),
    .commit(commit), .soft_reset(soft_reset), .dirty(dirty_d),
    .addr_err(ae_d), .err_count(ec_d));

  config_regfile #(.WIDTH(8), .NUMREGS(16), .ADDRW(8), .SHADOW_EN(1'b1),
    .DEFAULTS(PSD_DEFAULTS), .RO_MASK(PSD_RO_MASK), .ERRW(4)) u_shd (
    .clk(clk), .reset_n(reset_n), .config_bits(cb_s), .write(write),
    .write_addr(write_addr), .write_data(write_data), .read(read),
    .read_addr(read_addr), .read_data(rd_s), .read_valid(rv_s),
    .commit(commit), .soft_reset(soft_reset), .dirty(dirty_s),
    .addr_err(ae_s), .err_count(ec_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; commit = 1'b0; soft_reset = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write = 1'b1; write_addr = a; write_data = d;
  endtask

  task automatic rd(input logic [7:0] a);
    read = 1'b1; read_addr = a;
  endtask

  initial begin
    reset_n = 1'b0; idle();
    write_addr = '0; write_data = '0; read_addr = '0;
    repeat (3) step();
    chk("rst_rv", rv_d, 0);
    chk("rst_rd", rd_d, 0);
    chk("rst_ae", ae_d, 0);
    chk("rst_ec", ec_s, 0);
    chk("rst_dirty", dirty_s, 0);
    chk("rst_cb3", cb_d[3], 8'hA5);

    reset_n = 1'b1; step();
    chk("dflt_cb3_s", cb_s[3], 8'hA5);
    chk("dflt_cb0_d", cb_d[0], 8'h00);

    rd(8'd3); step(); idle();
    chk("rd3_valid", rv_d, 1);
    chk("rd3_data_d", rd_d, 8'hA5);
    chk("rd3_data_s", rd_s, 8'hA5);
    step();
    chk("rd_valid_drop", rv_d, 0);
    chk("rd_hold", rd_d, 8'hA5);

    wr(8'd5, 8'h3C); rd(8'd5); step(); idle();
    chk("dir_wr5", cb_d[5], 8'h3C);
    chk("dir_rbw", rd_d, 8'h00);
    chk("shd_cb5_held", cb_s[5], 8'h00);
    chk("shd_dirty", dirty_s, 1);
    chk("dir_no_dirty", dirty_d, 0);
    rd(8'd5); step(); idle();
    chk("dir_rd5", rd_d, 8'h3C);
    chk("shd_rd5", rd_s, 8'h3C);

    for (int i = 0; i < 3; i++) begin
      wr(8'(i), 8'(8'h11 * (i + 1))); step();
    end
    idle();
    chk("shd_cb0_held", cb_s[0], 8'h00);
    chk("shd_cb1_held", cb_s[1], 8'h00);
    chk("dir_cb2", cb_d[2], 8'h33);
    chk("shd_dirty2", dirty_s, 1);
    rd(8'd1); step(); idle();
    chk("shd_rd1", rd_s, 8'h22);

    commit = 1'b1; step(); idle();
    chk("cmt_cb0", cb_s[0], 8'h11);
    chk("cmt_cb1", cb_s[1], 8'h22);
    chk("cmt_cb2", cb_s[2], 8'h33);
    chk("cmt_cb5", cb_s[5], 8'h3C);
    chk("cmt_dirty", dirty_s, 0);

    commit = 1'b1; wr(8'd0, 8'h44); step(); idle();
    chk("cmtwr_cb0", cb_s[0], 8'h11);
    chk("cmtwr_dirty", dirty_s, 1);
    chk("cmtwr_dir", cb_d[0], 8'h44);
    rd(8'd0); step(); idle();
    chk("cmtwr_shadow", rd_s, 8'h44);

    wr(8'd7, 8'hFF); step(); idle();
    chk("ro_err", ae_d, 1);
    chk("ro_keep", cb_d[7], 8'h00);
    chk("ro_cnt", ec_d, 1);
    step();
    chk("err_pulse", ae_d, 0);
    rd(8'h20); step(); idle();
    chk("oor_rd_data", rd_d, 8'h00);
    chk("oor_rd_valid", rv_d, 1);
    chk("oor_rd_err", ae_s, 1);
    chk("oor_rd_cnt", ec_s, 2);
    wr(8'h10, 8'h01); rd(8'hFF); step(); idle();
    chk("dual_err_cnt", ec_d, 3);
    wr(8'h40, 8'h00);
    repeat (20) step();
    idle();
    chk("sat_cnt", ec_d, 15);
    step();
    chk("sat_hold", ec_s, 15);

    wr(8'd1, 8'h5A); step(); idle();
    soft_reset = 1'b1; commit = 1'b1; rd(8'd1); step(); idle();
    chk("srst_cb1", cb_s[1], 8'h00);
    chk("srst_cb3", cb_s[3], 8'hA5);
    chk("srst_dir_cb1", cb_d[1], 8'h00);
    chk("srst_dirty", dirty_s, 0);
    chk("srst_cnt", ec_d, 0);
    chk("srst_rd_pre_s", rd_s, 8'h5A);
    chk("srst_rd_pre_d", rd_d, 8'h5A);
    rd(8'd1); step(); idle();
    chk("srst_shadow", rd_s, 8'h00);
    commit = 1'b1; step(); idle();
    chk("cmt_clean_cb3", cb_s[3], 8'hA5);
    chk("cmt_clean_cb0", cb_s[0], 8'h00);

    wr(8'd2, 8'h77); step(); idle();
    rd(8'd3); step(); idle();
    chk("pre_ar_cb2", cb_d[2], 8'h77);
    chk("pre_ar_rd", rd_d, 8'hA5);
    rd(8'd2); wr(8'd7, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_rv", rv_d, 0);
    chk("ar_rd", rd_d, 8'h00);
    chk("ar_cb2", cb_d[2], 8'h00);
    idle(); step();
    chk("ar_no_valid", rv_d, 0);
    chk("ar_no_err", ae_d, 0);
    reset_n = 1'b1; step();
    chk("ar_rv_s", rv_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
